// File: rtl/jk_bank_arbiter_if.sv
// Command bus between the requesting agents and the JK bank arbiter.
// Each requester drives a request, a {j,k} opcode and a cell address, and the arbiter returns a one-hot grant.
interface jk_bank_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [AW*NREQ-1:0] addr;
    logic [NREQ-1:0]    gnt;

    modport master (output req, op, addr, input gnt);
    modport slave  (input req, op, addr, output gnt);
endinterface

// File: rtl/jk_bank_arbiter.sv
// Bank of WIDTH JK cells with a round-robin arbiter.
// The arbiter picks one requester per clock, and the winning {j,k} opcode is applied to the addressed cell.
module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic                 clk,
    input  logic                 preset,
    jk_bank_arbiter_if.slave     bus,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic                 upd_valid,
    output logic [2:0]           upd_id,
    output logic [AW-1:0]        upd_addr,
    output logic                 err
);
    logic [1:0]        op_arr   [NREQ];
    logic [AW-1:0]     addr_arr [NREQ];

    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   elig;
    logic [2*NREQ-1:0] elig_dbl;
    logic [NREQ-1:0]   elig_rot;
    logic [2:0]        ptr_reg, ptr_next;
    logic              win_found;
    logic [2:0]        win_id;
    logic [1:0]        win_op;
    logic [AW-1:0]     win_addr;
    logic              in_range;
    int                win_off;
    int                win_int;

    logic [WIDTH-1:0]  q_reg, q_next;
    logic              upd_valid_reg;
    logic [2:0]        upd_id_reg;
    logic [AW-1:0]     upd_addr_reg;
    logic              err_reg;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign op_arr[gi]   = bus.op[2*gi +: 2];
            assign addr_arr[gi] = bus.addr[AW*gi +: AW];
        end
    endgenerate

    // A requester granted on the previous edge is masked, so its still-held req is not served twice.
    assign elig     = bus.req & ~gnt_reg;
    assign elig_dbl = {elig, elig} >> ptr_reg;
    assign elig_rot = elig_dbl[NREQ-1:0];

    always_comb begin
        win_found = 1'b0;
        win_off   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                win_found = 1'b1;
                win_off   = i;
            end
        end
        win_int  = (int'(ptr_reg) + win_off) % NREQ;
        win_id   = 3'(win_int);
        ptr_next = 3'((win_int + 1) % NREQ);
        gnt_next = win_found ? (NREQ'(1) << win_id) : '0;

        win_op   = '0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == 3'(i)) begin
                win_op   = op_arr[i];
                win_addr = addr_arr[i];
            end
        end
        in_range = int'(win_addr) < WIDTH;
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            always_comb begin
                q_next[gi] = q_reg[gi];
                if (win_found && in_range && (win_addr == AW'(gi))) begin
                    case (win_op)
                        2'b01:   q_next[gi] = 1'b0;
                        2'b10:   q_next[gi] = 1'b1;
                        2'b11:   q_next[gi] = ~q_reg[gi];
                        default: q_next[gi] = q_reg[gi];
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (preset) begin
            q_reg         <= '0;
            gnt_reg       <= '0;
            upd_valid_reg <= 1'b0;
            upd_id_reg    <= '0;
            upd_addr_reg  <= '0;
            err_reg       <= 1'b0;
            ptr_reg       <= '0;
        end else begin
            q_reg         <= q_next;
            gnt_reg       <= gnt_next;
            upd_valid_reg <= win_found;
            if (win_found) begin
                upd_id_reg   <= win_id;
                upd_addr_reg <= win_addr;
                ptr_reg      <= ptr_next;
                if (!in_range) begin
                    err_reg <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt   = gnt_reg;
    assign q         = q_reg;
    assign qn        = ~q_reg;
    assign upd_valid = upd_valid_reg;
    assign upd_id    = upd_id_reg;
    assign upd_addr  = upd_addr_reg;
    assign err       = err_reg;
endmodule
